aes_shift_rows_stream: RTL and testbench

//  Byte-serial AES ShiftRows engine for the encrypt path (forward direction; INVERSE=1 gives decrypt).

---
 rtl/aes_shift_rows_stream.sv | 117 +++++++++++
 tb/tb_aes_shift_rows_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_stream.sv
// Byte-serial AES ShiftRows engine: collects a 16-byte state and applies the row rotation.
// The state is streamed back out one byte at a time and is also presented as a 128-bit word.
module aes_shift_rows_stream #(
   parameter bit INVERSE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_byte,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [7:0]   out_byte,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic [127:0] shifted_state,
   output logic         state_valid,
   output logic         busy
);

   typedef enum logic [1:0] {FILL, XFORM, DRAIN} StateT;

   StateT        r_state;
   StateT        w_nextState;
   logic [3:0]   r_inCnt;
   logic [3:0]   r_outCnt;
   logic [7:0]   r_buffer [16];
   logic [7:0]   w_bufNext [16];
   logic [127:0] r_shifted;
   logic [127:0] w_shifted;
   logic [6:0]   w_outBase;
   logic         w_inXfer;
   logic         w_outXfer;
   logic         w_lastIn;

   function automatic logic [3:0] srcIndex(input int c, input int r);
      if (INVERSE) return 4'(4 * ((c - r + 4) % 4) + r);
      else         return 4'(4 * ((c + r) % 4) + r);
   endfunction

   assign w_inXfer  = in_valid && in_ready;
   assign w_outXfer = out_valid && out_ready;
   assign w_lastIn  = w_inXfer && (r_inCnt == 4'd15);
   assign w_outBase = ~{r_outCnt, 3'b000};
   assign shifted_state = r_shifted;

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         w_bufNext[k] = (w_inXfer && (r_inCnt == 4'(k))) ? in_byte : r_buffer[k];
      end
   end

   always_comb begin
      w_shifted = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_shifted[127 - 8 * (4 * c + r) -: 8] = w_bufNext[srcIndex(c, r)];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= FILL;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FILL:    if (w_lastIn) w_nextState = XFORM;
         XFORM:   w_nextState = DRAIN;
         DRAIN:   if (w_outXfer && (r_outCnt == 4'd15)) w_nextState = FILL;
         default: w_nextState = FILL;
      endcase
   end

   // The permuted word is captured on the final fill transfer (with the
   // incoming byte bypassed) so shifted_state is already valid during the
   // one-cycle state_valid pulse in XFORM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inCnt   <= 4'd0;
         r_outCnt  <= 4'd0;
         r_shifted <= '0;
         for (int k = 0; k < 16; k++) r_buffer[k] <= 8'h00;
      end else begin
         for (int k = 0; k < 16; k++) r_buffer[k] <= w_bufNext[k];
         if (w_inXfer) r_inCnt <= r_inCnt + 4'd1;
         if (w_lastIn) r_shifted <= w_shifted;
         if (r_state == XFORM) r_outCnt <= 4'd0;
         else if (w_outXfer)   r_outCnt <= r_outCnt + 4'd1;
      end
   end

   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_byte    = 8'h00;
      state_valid = 1'b0;
      busy        = 1'b0;
      case (r_state)
         FILL: in_ready = 1'b1;
         XFORM: begin
            state_valid = 1'b1;
            busy        = 1'b1;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (r_outCnt == 4'd15);
            out_byte  = r_shifted[w_outBase -: 8];
            busy      = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// Directed bench for aes_shift_rows_stream: forward and inverse instances, which can be
// chained so that the forward output feeds the inverse input.
module tb_aes_shift_rows_stream;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]   fIn, iIn;
   logic         fInValid, iInValid, fOutReady, iOutReady;
   logic         chain, useInv;

   logic         fInReady, fOutValid, fOutLast, fStateValid, fBusy;
   logic [7:0]   fOutByte;
   logic [127:0] fShifted;
   logic         iInReady, iOutValid, iOutLast, iStateValid, iBusy;
   logic [7:0]   iOutByte;
   logic [127:0] iShifted;

   logic [7:0]   iInMux;
   logic         iInValidMux, fOutReadyMux;
   assign iInMux       = chain ? fOutByte  : iIn;
   assign iInValidMux  = chain ? fOutValid : iInValid;
   assign fOutReadyMux = chain ? iInReady  : fOutReady;

   logic         curInReady, curOutValid, curOutLast;
   logic [7:0]   curOutByte;
   assign curInReady  = useInv ? iInReady  : fInReady;
   assign curOutValid = useInv ? iOutValid : fOutValid;
   assign curOutLast  = useInv ? iOutLast  : fOutLast;
   assign curOutByte  = useInv ? iOutByte  : fOutByte;

   aes_shift_rows_stream #(.INVERSE(1'b0)) dutFwd (
      .clk(clk), .rst(rst),
      .in_byte(fIn), .in_valid(fInValid), .in_ready(fInReady),
      .out_byte(fOutByte), .out_valid(fOutValid), .out_ready(fOutReadyMux),
      .out_last(fOutLast), .shifted_state(fShifted),
      .state_valid(fStateValid), .busy(fBusy)
   );

   aes_shift_rows_stream #(.INVERSE(1'b1)) dutInv (
      .clk(clk), .rst(rst),
      .in_byte(iInMux), .in_valid(iInValidMux), .in_ready(iInReady),
      .out_byte(iOutByte), .out_valid(iOutValid), .out_ready(iOutReady),
      .out_last(iOutLast), .shifted_state(iShifted),
      .state_valid(iStateValid), .busy(iBusy)
   );

   int assertCount = 0;
   int failCount   = 0;

   localparam logic [127:0] BLK0  = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] BLK1  = 128'h101112131415161718191A1B1C1D1E1F;
   localparam logic [127:0] EXPF0 = 128'h00050A0F04090E03080D02070C01060B;
   localparam logic [127:0] EXPI0 = 128'h000D0A0704010E0B0805020F0C090603;
   localparam logic [127:0] EXPF1 = 128'h10151A1F14191E13181D12171C11161B;

   logic [127:0] chainIn  [2];
   logic [127:0] chainFwd [2];

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic setIn(input logic v, input logic [7:0] b);
      if (useInv) begin iInValid = v; iIn = b; end
      else        begin fInValid = v; fIn = b; end
   endtask

   task automatic setReady(input logic r);
      if (useInv) iOutReady = r;
      else        fOutReady = r;
   endtask

   // Feeds nBytes of blk starting from its top byte; gap idle cycles follow each transfer.
   task automatic applyStimulus(input logic [127:0] blk, input int nBytes, input int gap);
      for (int k = 0; k < nBytes; k++) begin
         int   budget;
         logic done;
         budget = 0;
         done   = 1'b0;
         setIn(1'b1, blk[127 - 8 * k -: 8]);
         while (!done) begin
            @(negedge clk);
            done = curInReady;
            @(posedge clk); #1;
            budget++;
            if (!done && budget > 100) begin
               checkOutput("feedTimeout", 128'd0, 128'd1);
               return;
            end
         end
         if (gap > 0 && k < nBytes - 1) begin
            setIn(1'b0, 8'h00);
            repeat (gap) begin @(posedge clk); #1; end
         end
      end
      setIn(1'b0, 8'h00);
   endtask

   // Collects nBytes of output, optionally stalling stallLen cycles once stallAt bytes have moved.
   task automatic collectOutput(input logic [127:0] exp, input int nBytes, input int stallAt,
                                input int stallLen, input string tag);
      logic [127:0] got;
      int n, stall, budget, readyViol, lastViol, holdViol;
      logic rdy;
      got = '0; n = 0; stall = 0; budget = 0; readyViol = 0; lastViol = 0; holdViol = 0;
      while (n < nBytes && budget < 300) begin
         if (n == stallAt && stall < stallLen) begin rdy = 1'b0; stall++; end
         else rdy = 1'b1;
         setReady(rdy);
         @(negedge clk);
         budget++;
         if (curInReady) readyViol++;
         if (!rdy && (!curOutValid || curOutByte !== exp[127 - 8 * n -: 8])) holdViol++;
         if (curOutValid && rdy) begin
            got = {got[119:0], curOutByte};
            if (curOutLast !== (n == 15)) lastViol++;
            n++;
         end
         @(posedge clk); #1;
      end
      setReady(1'b1);
      checkOutput({tag, "_bytes"}, got, exp >> (8 * (16 - nBytes)));
      checkOutput({tag, "_inReadyLow"}, 128'(readyViol), 128'd0);
      checkOutput({tag, "_last"}, 128'(lastViol), 128'd0);
      if (stallLen > 0) checkOutput({tag, "_hold"}, 128'(holdViol), 128'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      chainIn[0]  = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
      chainFwd[0] = 128'h19F48D08A0C648BE9AF8E32BE93DE22A;
      chainIn[1]  = 128'hD42711AEE0BF98F1B8B45DE51E415230;
      chainFwd[1] = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
      rst = 1'b1; chain = 1'b0; useInv = 1'b0;
      fIn = 8'h00; iIn = 8'h00; fInValid = 1'b0; iInValid = 1'b0;
      fOutReady = 1'b1; iOutReady = 1'b1;

      #12;
      checkOutput("resetFwdCtl", {fInReady, fOutValid, fOutLast, fStateValid, fBusy, fOutByte},
                  {1'b1, 4'b0000, 8'h00});
      checkOutput("resetFwdState", fShifted, 128'h0);
      checkOutput("resetInvCtl", {iInReady, iOutValid, iOutLast, iStateValid, iBusy, iOutByte},
                  {1'b1, 4'b0000, 8'h00});
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Forward permutation, latency and the XFORM cycle
      applyStimulus(BLK0, 16, 0);
      @(negedge clk);
      checkOutput("t1_xformCtl", {fStateValid, fOutValid, fInReady, fBusy}, 4'b1001);
      checkOutput("t1_xformState", fShifted, EXPF0);
      @(posedge clk); #1;
      checkOutput("t1_latency", fOutValid, 1'b1);
      collectOutput(EXPF0, 16, -1, 0, "t1");
      checkOutput("t1_stateHeld", fShifted, EXPF0);

      // Inverse permutation
      useInv = 1'b1;
      applyStimulus(BLK0, 16, 0);
      collectOutput(EXPI0, 16, -1, 0, "t2");
      checkOutput("t2_state", iShifted, EXPI0);

      // Forward chained into inverse must reproduce the input
      for (int i = 0; i < 2; i++) begin
         int w;
         chain = 1'b1; useInv = 1'b0;
         applyStimulus(chainIn[i], 16, 0);
         w = 0;
         do begin @(negedge clk); w++; end while (fBusy && w < 100);
         checkOutput("t3_fwdDone", fBusy, 1'b0);
         checkOutput("t3_fwdState", fShifted, chainFwd[i]);
         useInv = 1'b1;
         collectOutput(chainIn[i], 16, -1, 0, "t3_chain");
         chain = 1'b0;
      end

      // Gappy input and a 3-cycle output stall
      useInv = 1'b0;
      applyStimulus(BLK0, 16, 2);
      collectOutput(EXPF0, 16, 5, 3, "t4");

      // Reset mid-fill discards the partial block
      applyStimulus(BLK0, 7, 0);
      rst = 1'b1; #1;
      checkOutput("t5_resetCtl", {fInReady, fBusy, fOutValid}, 3'b100);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("t5_resetState", fShifted, 128'h0);
      applyStimulus(BLK1, 16, 0);
      collectOutput(EXPF1, 16, -1, 0, "t5a");

      // Reset mid-drain
      applyStimulus(BLK0, 16, 0);
      collectOutput(EXPF0, 9, -1, 0, "t5b_part");
      rst = 1'b1; #1;
      checkOutput("t5b_asyncValid", fOutValid, 1'b0);
      @(negedge clk);
      checkOutput("t5b_cycleAfter", {fOutValid, fOutLast, fInReady}, 3'b001);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(BLK1, 16, 0);
      collectOutput(EXPF1, 16, -1, 0, "t5b");

      // Second block held on in_valid through XFORM and DRAIN
      applyStimulus(BLK0, 16, 0);
      setIn(1'b1, BLK1[127:120]);
      collectOutput(EXPF0, 16, -1, 0, "t6a");
      checkOutput("t6_readyAfterLast", fInReady, 1'b1);
      applyStimulus(BLK1, 16, 0);
      collectOutput(EXPF1, 16, -1, 0, "t6b");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
